// File: rtl/token_merger.sv
// token_merger: greedy left-to-right pairwise token merge against a vocab buffer.
// Optional feature macro TOKEN_MERGER_MULTIPASS_EN adds internal ping-pong passes.
module token_merger #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int VOCAB_ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] DELIM = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef TOKEN_MERGER_MULTIPASS_EN
  input  logic [3:0]                  max_pass,
  output logic [3:0]                  pass_count,
  output logic [ADDR_WIDTH-1:0]       out_rd_addr,
  input  logic [DATA_WIDTH-1:0]       out_rd_data,
  output logic                        buf_sel,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [VOCAB_ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0]       voc_data,
  output logic                        out_we,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ADDR_WIDTH-1:0]       merge_count,
  output logic                        overflow
);

  typedef logic [ADDR_WIDTH-1:0]       addr_t;
  typedef logic [ADDR_WIDTH:0]         len_t;
  typedef logic [VOCAB_ADDR_WIDTH-1:0] vaddr_t;
  typedef logic [DATA_WIDTH-1:0]       sym_t;

  typedef enum logic [3:0] {
    IDLE, FIND_A, FIND_B, VCMP, VSKIP,
    EMIT_A, EMIT_AB, FINISH, DONE
  } state_t;

  state_t state_q, state_d;
  len_t   k_q, k_d, tk_q, tk_d;
  logic   vld_q, vld_d;
  addr_t  nxt_q, nxt_d;
  addr_t  a_start_q, a_start_d;
  len_t   a_len_q, a_len_d;
  addr_t  b_start_q, b_start_d;
  len_t   b_len_q, b_len_d;
  logic   eos_q, eos_d;
  logic   b_none_q, b_none_d;
  vaddr_t ve_q, ve_d;
  addr_t  optr_q, optr_d;
  addr_t  mcnt_q, mcnt_d;
  logic   ovf_q, ovf_d;

  sym_t   rd_data;
  addr_t  ia;
  len_t   ab_len, elen, kb, tlen;
  addr_t  map_a, scan_pos, mcnt_inc;
  vaddr_t vaddr;
  logic   at_last, v_last, is_delim;

`ifdef TOKEN_MERGER_MULTIPASS_EN
  logic [3:0] pass_q, pass_d;
  logic       bsel_q, bsel_d;
  // bsel_q=1: source is the output buffer, writes land in the input buffer
  assign rd_data     = bsel_q ? out_rd_data : in_data;
  assign out_rd_addr = ia;
  assign pass_count  = pass_q;
  assign buf_sel     = bsel_q;
`else
  assign rd_data = in_data;
`endif

  assign in_addr     = ia;
  assign out_addr    = optr_q;
  assign merge_count = mcnt_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);

  assign ab_len   = a_len_q + b_len_q;
  assign kb       = k_q - a_len_q;
  // Position k of the A||B concatenation mapped onto the input buffer
  assign map_a    = (k_q < a_len_q) ? a_start_q + addr_t'(k_q)
                                    : b_start_q + addr_t'(kb);
  assign scan_pos = nxt_q + addr_t'(tk_q);
  assign at_last  = (scan_pos == '1);
  assign vaddr    = ve_q + vaddr_t'(tk_q);
  assign v_last   = (vaddr == '1);
  assign is_delim = (rd_data == DELIM);
  assign tlen     = is_delim ? tk_q : tk_q + len_t'(1);
  assign elen     = (state_q == EMIT_AB) ? ab_len : a_len_q;
  assign mcnt_inc = (&mcnt_q) ? mcnt_q : mcnt_q + addr_t'(1);

  always_comb begin
    ia       = '0;
    voc_addr = '0;
    case (state_q)
      FIND_A, FIND_B: ia = nxt_q + addr_t'(k_q);
      VCMP: begin
        ia       = map_a;
        voc_addr = ve_q + vaddr_t'(k_q);
      end
      VSKIP: voc_addr = ve_q + vaddr_t'(k_q);
      EMIT_A, EMIT_AB: ia = map_a;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tk_d      = k_q;
    vld_d     = 1'b0;
    nxt_d     = nxt_q;
    a_start_d = a_start_q;
    a_len_d   = a_len_q;
    b_start_d = b_start_q;
    b_len_d   = b_len_q;
    eos_d     = eos_q;
    b_none_d  = b_none_q;
    ve_d      = ve_q;
    optr_d    = optr_q;
    mcnt_d    = mcnt_q;
    ovf_d     = ovf_q;
    out_we    = 1'b0;
    out_data  = '0;
    done      = 1'b0;
`ifdef TOKEN_MERGER_MULTIPASS_EN
    pass_d    = pass_q;
    bsel_d    = bsel_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FIND_A;
          k_d      = '0;
          nxt_d    = '0;
          optr_d   = '0;
          mcnt_d   = '0;
          ovf_d    = 1'b0;
          eos_d    = 1'b0;
          b_none_d = 1'b0;
`ifdef TOKEN_MERGER_MULTIPASS_EN
          pass_d   = '0;
          bsel_d   = 1'b0;
`endif
        end
      end
      FIND_A, FIND_B: begin
        vld_d = 1'b1;
        k_d   = k_q + len_t'(1);
        if (vld_q && (is_delim || at_last)) begin
          k_d   = '0;
          vld_d = 1'b0;
          nxt_d = scan_pos + addr_t'(1);
          if (state_q == FIND_A) begin
            if (tlen == '0) begin
              state_d = FINISH;
            end else begin
              a_start_d = nxt_q;
              a_len_d   = tlen;
              eos_d     = at_last;
              b_none_d  = at_last;
              state_d   = at_last ? EMIT_A : FIND_B;
            end
          end else if (tlen == '0) begin
            b_none_d = 1'b1;
            eos_d    = 1'b1;
            state_d  = EMIT_A;
          end else begin
            b_start_d = nxt_q;
            b_len_d   = tlen;
            eos_d     = at_last;
            ve_d      = '0;
            state_d   = VCMP;
          end
        end
      end
      VCMP: begin
        vld_d = 1'b1;
        k_d   = (k_q < ab_len) ? k_q + len_t'(1) : k_q;
        if (vld_q) begin
          if (tk_q == '0 && voc_data == DELIM) begin
            state_d = EMIT_A;
          end else if (tk_q == ab_len) begin
            if (voc_data == DELIM) begin
              state_d = EMIT_AB;
            end else begin
              ve_d    = vaddr;
              state_d = VSKIP;
            end
          end else if (voc_data != rd_data) begin
            ve_d    = vaddr;
            state_d = VSKIP;
          end else if (v_last) begin
            // last vocab symbol carries an implicit delimiter
            state_d = (tk_q + len_t'(1) == ab_len) ? EMIT_AB : EMIT_A;
          end
          if (state_d != VCMP) begin
            k_d   = '0;
            vld_d = 1'b0;
          end
        end
      end
      VSKIP: begin
        vld_d = 1'b1;
        k_d   = k_q + len_t'(1);
        if (vld_q && (v_last || voc_data == DELIM)) begin
          k_d     = '0;
          vld_d   = 1'b0;
          ve_d    = vaddr + vaddr_t'(1);
          state_d = v_last ? EMIT_A : VCMP;
        end
      end
      EMIT_A, EMIT_AB: begin
        vld_d = 1'b1;
        k_d   = (k_q < elen) ? k_q + len_t'(1) : k_q;
        if (vld_q) begin
          out_we = 1'b1;
          if (optr_q == '1) begin
            out_data = DELIM;
            ovf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            out_data = (tk_q < elen) ? rd_data : DELIM;
            optr_d   = optr_q + addr_t'(1);
            if (tk_q == elen) begin
              k_d   = '0;
              vld_d = 1'b0;
              if (state_q == EMIT_AB) begin
                mcnt_d  = mcnt_inc;
                state_d = eos_q ? FINISH : FIND_A;
              end else if (b_none_q) begin
                state_d = FINISH;
              end else begin
                a_start_d = b_start_q;
                a_len_d   = b_len_q;
                b_none_d  = eos_q;
                state_d   = eos_q ? EMIT_A : FIND_B;
              end
            end
          end
        end
      end
      FINISH: begin
        out_we   = 1'b1;
        out_data = DELIM;
        state_d  = DONE;
`ifdef TOKEN_MERGER_MULTIPASS_EN
        if (mcnt_q != '0 &&
            ({1'b0, pass_q} + 5'd1) < {1'b0, max_pass}) begin
          state_d  = FIND_A;
          k_d      = '0;
          nxt_d    = '0;
          optr_d   = '0;
          mcnt_d   = '0;
          eos_d    = 1'b0;
          b_none_d = 1'b0;
          pass_d   = pass_q + 4'd1;
          bsel_d   = ~bsel_q;
        end
`endif
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      tk_q      <= '0;
      vld_q     <= 1'b0;
      nxt_q     <= '0;
      a_start_q <= '0;
      a_len_q   <= '0;
      b_start_q <= '0;
      b_len_q   <= '0;
      eos_q     <= 1'b0;
      b_none_q  <= 1'b0;
      ve_q      <= '0;
      optr_q    <= '0;
      mcnt_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef TOKEN_MERGER_MULTIPASS_EN
      pass_q    <= '0;
      bsel_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tk_q      <= tk_d;
      vld_q     <= vld_d;
      nxt_q     <= nxt_d;
      a_start_q <= a_start_d;
      a_len_q   <= a_len_d;
      b_start_q <= b_start_d;
      b_len_q   <= b_len_d;
      eos_q     <= eos_d;
      b_none_q  <= b_none_d;
      ve_q      <= ve_d;
      optr_q    <= optr_d;
      mcnt_q    <= mcnt_d;
      ovf_q     <= ovf_d;
`ifdef TOKEN_MERGER_MULTIPASS_EN
      pass_q    <= pass_d;
      bsel_q    <= bsel_d;
`endif
    end
  end

endmodule

// File: tb/tb_token_merger.sv
// tb_token_merger: directed passes with a write scoreboard for token_merger.
// Expected writes are queued by the stimulus and popped by a negedge monitor.
module tb_token_merger;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, out_we, overflow;
  logic [3:0] in_addr, voc_addr, out_addr, merge_count;
  logic [7:0] in_data, voc_data, out_data;

  logic [7:0] in_mem [16];
  logic [7:0] voc_mem [16];

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  int  ncyc;
  int  d0;

  token_merger dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .voc_addr(voc_addr), .voc_data(voc_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .merge_count(merge_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data  <= in_mem[in_addr];
    voc_data <= voc_mem[voc_addr];
  end

  always @(negedge clk) begin
    if (out_we) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL write_extra: got addr %0d data %h, required no write",
                 out_addr, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.a != out_addr || mon_e.d != out_data) begin
          fails++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   out_addr, out_data, mon_e.a, mon_e.d);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic set_in(input int n, input logic [127:0] v);
    for (int i = 0; i < 16; i++)
      in_mem[i] = (i < n) ? v[8*(n-1-i) +: 8] : 8'h5a;
  endtask

  task automatic set_voc(input int n, input logic [127:0] v);
    for (int i = 0; i < 16; i++)
      voc_mem[i] = (i < n) ? v[8*(n-1-i) +: 8] : 8'h77;
  endtask

  task automatic expect_out(input int n, input logic [127:0] v);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = 4'(i);
      e.d = v[8*(n-1-i) +: 8];
      sb.push_back(e);
    end
  endtask

  task automatic run_pass(input int glitch, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == glitch);
      seen = done;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_pass(input string name, input logic [3:0] mc,
                             input logic ovf, input int dstart);
    repeat (4) @(negedge clk);
    check({name, "_missing_writes"}, 32'(sb.size()), 32'd0);
    check({name, "_merge_count"}, 32'(merge_count), 32'(mc));
    check({name, "_overflow"}, 32'(overflow), 32'(ovf));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done_pulses"}, 32'(done_cnt - dstart), 32'd1);
  endtask

  initial begin
    set_in(1, 128'h00);
    set_voc(1, 128'h00);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {29'd0, busy, done, out_we}, 32'd0);
    check("rst_addr", {20'd0, in_addr, voc_addr, out_addr}, 32'd0);
    check("rst_stat", {27'd0, merge_count, overflow}, 32'd0);
    rst = 1'b0;

    // single merge of "ab"+"c"
    set_in(8, 128'h6162_0063_0064_0000);
    set_voc(5, 128'h61_6263_0000);
    expect_out(7, 128'h61_6263_0064_0000);
    d0 = done_cnt;
    run_pass(0, ncyc);
    finish_pass("merge1", 4'd1, 1'b0, d0);

    // empty vocab: pass-through
    set_voc(1, 128'h00);
    expect_out(8, 128'h6162_0063_0064_0000);
    d0 = done_cnt;
    run_pass(0, ncyc);
    finish_pass("novocab", 4'd0, 1'b0, d0);

    // empty input
    set_in(1, 128'h00);
    set_voc(5, 128'h61_6263_0000);
    expect_out(1, 128'h00);
    d0 = done_cnt;
    run_pass(0, ncyc);
    check("empty_latency_le4", 32'(ncyc <= 4), 32'd1);
    finish_pass("empty", 4'd0, 1'b0, d0);

    // two merges, start pulsed mid-pass
    set_in(9, 128'h61_0061_0061_0061_0000);
    set_voc(4, 128'h6161_0000);
    expect_out(7, 128'h61_6100_6161_0000);
    d0 = done_cnt;
    run_pass(5, ncyc);
    finish_pass("merge2", 4'd2, 1'b0, d0);

    // vocab skipping: first two entries mismatch, third matches
    set_in(5, 128'h61_0062_0000);
    set_voc(9, 128'h61_0061_6300_6162_0000);
    expect_out(4, 128'h6162_0000);
    d0 = done_cnt;
    run_pass(0, ncyc);
    finish_pass("vskip", 4'd1, 1'b0, d0);

    // unterminated 16-symbol input overflows the output buffer
    set_in(16, 128'h6100_6100_6100_6100_6100_6100_6100_6162);
    set_voc(1, 128'h00);
    expect_out(16, 128'h6100_6100_6100_6100_6100_6100_6100_6100);
    d0 = done_cnt;
    run_pass(0, ncyc);
    finish_pass("overflow", 4'd0, 1'b1, d0);

    // rerun aborted by reset
    expect_out(16, 128'h6100_6100_6100_6100_6100_6100_6100_6100);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we", 32'(out_we), 32'd0);
    check("rst_mid_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check("rst_mid_idle_we", 32'(out_we), 32'd0);

    // recovery after reset
    set_in(8, 128'h6162_0063_0064_0000);
    set_voc(5, 128'h61_6263_0000);
    expect_out(7, 128'h61_6263_0064_0000);
    d0 = done_cnt;
    run_pass(0, ncyc);
    finish_pass("recover", 4'd1, 1'b0, d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
